drenador_fifos: RTL
===================

Name: drenador_fifos

Overview:
- Egress drain stage of the transaction layer; sits directly upstream of the pop-counter block.
- Empties the four output FIFOs (channels 0-3) one word per cycle in round-robin order.
- Drives the per-channel pop strobes and the idle flag that the counter block consumes.
- Forwards each popped word with a valid strobe to the next layer.

Parameters:
DATA_W, 10, width of each FIFO word and of data_out
(channel count fixed at 4)

Ports:
clk  input  1  rising-edge clock
rst_l  input  1  synchronous reset, active-low
init  input  1  re-initialisation request from the controller
pause  input  1  downstream back-pressure; no pops while high
empty_0..empty_3  input  1 each  FIFO empty flags (registered in FIFO)
data_in0..data_in3  input  DATA_W each  FIFO head word (first-word-fall-through)
pop_0..pop_3  output  1 each  pop strobe to FIFO n and to the counter block
data_out  output  DATA_W  word popped in the previous cycle
valid_out  output  1  data_out qualifier
idle  output  1  high in IDLE state
state  output  2  current FSM state (debug/observability)

Behaviour:
- Reset: rst_l sampled low at a rising clk edge forces state=RESET, rr pointer=0, data_out=0, valid_out=0.
  - While state=RESET: pop_0..3=0 and idle=0.
  - rst_l has priority over every other input.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- Transitions, evaluated each rising edge:
  - RESET -> INIT on the first edge with rst_l=1.
  - INIT -> IDLE when init=0; INIT holds while init=1.
  - IDLE -> ACTIVE when pause=0 and any empty_n=0.
  - ACTIVE -> IDLE when pause=1, or when all empty_n=1.
  - Any state except RESET -> INIT when init=1. init has priority over the IDLE/ACTIVE transitions.
- Pops:
  - pop_n is combinational and is asserted only when state=ACTIVE, pause=0 and empty_n=0.
  - At most one pop_n is high per cycle.
- Arbitration: search channels starting at rr and wrap 3->0. The first non-empty channel is granted.
  - On a grant to channel g, rr <= (g+1) mod 4.
  - rr is unchanged when there is no grant.
- Datapath:
  - On the edge ending a cycle with pop_g=1: data_out <= data_in_g and valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its last value.
  - Latency: pop to valid_out is 1 cycle.
- Boundary conditions:
  - pause rising mid-stream: pops stop in the same cycle (combinational gate). The last word still appears on the following cycle with valid_out=1.
  - Single-entry FIFO: after its pop, the FIFO raises empty_n the next cycle and the channel is skipped from then on.
  - init asserted in ACTIVE: pops stop the same cycle. A word already popped still emerges with valid_out=1. rr is reset to 0.
  - Reset mid-operation: valid_out clears on the reset edge. Pending FIFO data is not consumed.
- Throughput: 1 word/cycle while ACTIVE and unpaused.
- Entering ACTIVE costs one bubble cycle (IDLE -> ACTIVE).

Test Plan:
- Reset release: rst_l low 2 cycles, then high with init=0 -> state 0, then 1, then 2. pops=0, valid_out=0, idle=1 from the third cycle.
- Single channel: empty_2=0 holding 3 words 0x101, 0x102, 0x103, others empty -> IDLE -> ACTIVE, then pop_2 for 3 cycles. data_out 0x101, 0x102, 0x103 each one cycle later with valid_out=1. Return to IDLE, idle=1.
- Round robin: all four FIFOs hold 2 words -> pop sequence ch0, 1, 2, 3, 0, 1, 2, 3. 8 valid words, never two pops in one cycle.
- Back-pressure: pause=1 for 3 cycles in the middle of the round-robin test -> pops drop the same cycle and the in-flight word still appears. State goes to IDLE, and the sequence resumes at the next rr channel after pause=0 plus one bubble.
- init mid-stream: assert init for 2 cycles while ACTIVE -> state=INIT, no pops, rr=0. After release, IDLE, then ACTIVE restarting at ch0.
- Counter cross-check: drive 5 pops on ch1 and 3 on ch3 -> the downstream counter block reads 5 and 3 on idx=1 and idx=3 with idle=1.

Source files
------------

// File: rtl/drenador_fifos_if.sv
// FIFO-side and egress-side bus of the drain stage.
// Latency: none (wires only).
// Backpressure: the pop strobes are the only flow control toward the FIFOs.
interface drenador_fifos_if #(
  parameter int DATA_W = 10
);
  logic              empty_0, empty_1, empty_2, empty_3;
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic              pop_0, pop_1, pop_2, pop_3;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  // Drain stage side: reads FIFO heads, drives pops and the egress word.
  modport master (
    input  empty_0, empty_1, empty_2, empty_3,
    input  data_in0, data_in1, data_in2, data_in3,
    output pop_0, pop_1, pop_2, pop_3,
    output data_out, valid_out
  );

  // FIFO / downstream side.
  modport slave (
    output empty_0, empty_1, empty_2, empty_3,
    output data_in0, data_in1, data_in2, data_in3,
    input  pop_0, pop_1, pop_2, pop_3,
    input  data_out, valid_out
  );
endinterface

// File: rtl/drenador_fifos.sv
// Round-robin drain of four FWFT FIFOs into one word-per-cycle egress stream.
// Latency: pop to valid_out is 1 cycle; entering ACTIVE costs one bubble cycle.
// Backpressure: pause gates pops combinationally; an already popped word still emerges.
module drenador_fifos #(
  parameter int DATA_W = 10
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        init,
  input  logic        pause,
  drenador_fifos_if.master bus,
  output logic        idle,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t            cur;
  logic [1:0]        rr;
  logic [3:0]        empty;
  logic [DATA_W-1:0] din [4];
  logic              any_data;
  logic              grant_vld;
  logic [1:0]        grant_ch;
  logic [1:0]        idx;
  logic              pop_en;
  logic [3:0]        pop_vec;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  assign empty    = {bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};
  assign din[0]   = bus.data_in0;
  assign din[1]   = bus.data_in1;
  assign din[2]   = bus.data_in2;
  assign din[3]   = bus.data_in3;
  assign any_data = ~&empty;

  // Pick the first non-empty channel searching upward from rr, wrapping 3->0.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = rr;
    idx       = rr;
    for (int i = 0; i < 4; i++) begin
      idx = rr + 2'(i);
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  // Pops fire only while draining; pause, init and reset all cut them in the same cycle.
  assign pop_en  = rst_l && (cur == S_ACTIVE) && !pause && !init && grant_vld;
  assign pop_vec = pop_en ? (4'b0001 << grant_ch) : 4'b0000;

  assign bus.pop_0     = pop_vec[0];
  assign bus.pop_1     = pop_vec[1];
  assign bus.pop_2     = pop_vec[2];
  assign bus.pop_3     = pop_vec[3];
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign state         = cur;

  // FSM, rr pointer and egress register; idle is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cur     <= S_RESET;
      rr      <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idle    <= 1'b0;
    end else begin
      valid_q <= pop_en;
      if (pop_en) begin
        data_q <= din[grant_ch];
        rr     <= grant_ch + 2'd1;
      end
      case (cur)
        S_RESET: begin
          cur  <= S_INIT;
          idle <= 1'b0;
        end
        S_INIT: begin
          if (!init) begin
            cur  <= S_IDLE;
            idle <= 1'b1;
          end
        end
        S_IDLE: begin
          if (init) begin
            cur  <= S_INIT;
            idle <= 1'b0;
            rr   <= 2'd0;
          end else if (!pause && any_data) begin
            cur  <= S_ACTIVE;
            idle <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (init) begin
            // Re-initialisation restarts arbitration from channel 0.
            cur  <= S_INIT;
            idle <= 1'b0;
            rr   <= 2'd0;
          end else if (pause || !any_data) begin
            cur  <= S_IDLE;
            idle <= 1'b1;
          end
        end
        default: begin
          cur  <= S_RESET;
          idle <= 1'b0;
        end
      endcase
    end
  end

endmodule
